// File: rtl/arc_halt_run_pkg.sv
// Shared types for the ARC halt/run sequencer.
// State, requester and operation encodings plus counter widths.
package arc_halt_run_pkg;

    localparam int CNT_W  = 16;
    localparam int WAKE_W = 4;

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_ACK_LOW,
        S_DONE
    } hr_state_e;

    typedef enum logic {
        RQ_DBG,
        RQ_PM
    } hr_who_e;

    typedef enum logic {
        OP_HALT,
        OP_RUN
    } hr_op_e;

    // True when the core is already in the state the op asks for.
    function automatic logic op_is_noop(hr_op_e op, logic halted);
        return (op == OP_HALT) ? halted : !halted;
    endfunction

endpackage

// File: rtl/arc_sync_2ff.sv
// Two-flop synchronizer for a single level signal.
// Resets to 0 asynchronously.
module arc_sync_2ff (
    input  logic ref_clk,
    input  logic erst_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge ref_clk or negedge erst_n) begin
        if (!erst_n) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/arc_halt_run_seq.sv
// Halt/run request sequencer between debug/PM hosts and the ARC core.
// Runs a 4-phase handshake with timeout and an independent wake pulse.
module arc_halt_run_seq
    import arc_halt_run_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int WAKE_PULSE     = 4
) (
    input  logic ref_clk,
    input  logic erst_n,
    input  logic dbg_halt_req,
    input  logic dbg_run_req,
    input  logic pm_halt_req,
    input  logic pm_run_req,
    output logic dbg_done,
    output logic pm_done,
    output logic arc_halt_req_a,
    output logic arc_run_req_a,
    input  logic arc_halt_ack,
    input  logic arc_run_ack,
    input  logic sys_halt_r,
    input  logic sys_sleep_r,
    input  logic wake_req,
    output logic arc_wake_evt_a,
    input  logic err_clr,
    output logic err_timeout,
    output logic busy
);

    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [WAKE_W-1:0] WAKE_LAST = WAKE_W'(WAKE_PULSE - 1);

    logic halt_ack_s;
    logic run_ack_s;

    arc_sync_2ff u_sync_halt (
        .ref_clk (ref_clk),
        .erst_n  (erst_n),
        .d       (arc_halt_ack),
        .q       (halt_ack_s)
    );

    arc_sync_2ff u_sync_run (
        .ref_clk (ref_clk),
        .erst_n  (erst_n),
        .d       (arc_run_ack),
        .q       (run_ack_s)
    );

    hr_state_e        state;
    hr_who_e          who;
    hr_op_e           op;
    logic [CNT_W-1:0] phase_cnt;

    hr_who_e arb_who;
    hr_op_e  arb_op;
    logic    any_req;
    logic    ack_s;
    logic    cnt_last;

    always_comb begin
        arb_who = RQ_PM;
        arb_op  = OP_RUN;
        if (dbg_halt_req) begin
            arb_who = RQ_DBG;
            arb_op  = OP_HALT;
        end else if (dbg_run_req) begin
            arb_who = RQ_DBG;
            arb_op  = OP_RUN;
        end else if (pm_halt_req) begin
            arb_who = RQ_PM;
            arb_op  = OP_HALT;
        end
    end

    assign any_req  = dbg_halt_req | dbg_run_req | pm_halt_req | pm_run_req;
    assign ack_s    = (op == OP_HALT) ? halt_ack_s : run_ack_s;
    assign cnt_last = (phase_cnt == CNT_LAST);

    always_ff @(posedge ref_clk or negedge erst_n) begin
        if (!erst_n) begin
            state          <= S_IDLE;
            who            <= RQ_DBG;
            op             <= OP_HALT;
            phase_cnt      <= '0;
            arc_halt_req_a <= 1'b0;
            arc_run_req_a  <= 1'b0;
            dbg_done       <= 1'b0;
            pm_done        <= 1'b0;
            err_timeout    <= 1'b0;
            busy           <= 1'b0;
        end else begin
            dbg_done <= 1'b0;
            pm_done  <= 1'b0;
            // A timeout below overrides this clear in the same cycle.
            if (err_clr) begin
                err_timeout <= 1'b0;
            end
            unique case (state)
                S_IDLE: begin
                    if (any_req) begin
                        who       <= arb_who;
                        op        <= arb_op;
                        busy      <= 1'b1;
                        phase_cnt <= '0;
                        if (op_is_noop(arb_op, sys_halt_r)) begin
                            state    <= S_DONE;
                            dbg_done <= (arb_who == RQ_DBG);
                            pm_done  <= (arb_who == RQ_PM);
                        end else begin
                            state          <= S_REQ;
                            arc_halt_req_a <= (arb_op == OP_HALT);
                            arc_run_req_a  <= (arb_op == OP_RUN);
                        end
                    end
                end
                S_REQ: begin
                    phase_cnt <= phase_cnt + 16'd1;
                    if (ack_s) begin
                        state          <= S_ACK_LOW;
                        phase_cnt      <= '0;
                        arc_halt_req_a <= 1'b0;
                        arc_run_req_a  <= 1'b0;
                    end else if (cnt_last) begin
                        state          <= S_DONE;
                        arc_halt_req_a <= 1'b0;
                        arc_run_req_a  <= 1'b0;
                        err_timeout    <= 1'b1;
                        dbg_done       <= (who == RQ_DBG);
                        pm_done        <= (who == RQ_PM);
                    end
                end
                S_ACK_LOW: begin
                    phase_cnt <= phase_cnt + 16'd1;
                    if (!ack_s) begin
                        state    <= S_DONE;
                        dbg_done <= (who == RQ_DBG);
                        pm_done  <= (who == RQ_PM);
                    end else if (cnt_last) begin
                        state       <= S_DONE;
                        err_timeout <= 1'b1;
                        dbg_done    <= (who == RQ_DBG);
                        pm_done     <= (who == RQ_PM);
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    // wake_left counts the pulse cycles still owed after the current one.
    logic [WAKE_W-1:0] wake_left;

    always_ff @(posedge ref_clk or negedge erst_n) begin
        if (!erst_n) begin
            arc_wake_evt_a <= 1'b0;
            wake_left      <= '0;
        end else if (wake_req && sys_sleep_r) begin
            arc_wake_evt_a <= 1'b1;
            wake_left      <= WAKE_LAST;
        end else if (arc_wake_evt_a) begin
            if (!sys_sleep_r || wake_left == '0) begin
                arc_wake_evt_a <= 1'b0;
            end else begin
                wake_left <= wake_left - 4'd1;
            end
        end
    end

endmodule
